sha_padder: RTL and testbench

SHA_PADDER -- requirements
Module: sha_padder

---
 rtl/sha_pkg.sv | 51 +++++
 rtl/sha_codec_decode.sv | 33 +++
 rtl/sha_padder.sv | 204 ++++++++++++++++++++
 tb/tb_sha_padder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared constants and types for the SHA message padder and codec decoder.
// Optional 1024-bit block support is enabled with SHA_PADDER_1024_EN.
package sha_pkg;

  // Bit offset of the 16-bit multicodec identifier inside TUSER.
  localparam int CODEC_POS = 0;

  // Codes as seen after the varint byte-swap rule. sha2-224 (0x1013) arrives as
  // the two-byte varint 93 20, which swaps to 16'h9320.
  localparam logic [15:0] CODEC_SHA2_224 = 16'h9320;
  localparam logic [15:0] CODEC_SHA2_256 = 16'h0012;
  localparam logic [15:0] CODEC_SHA2_384 = 16'h0020;
  localparam logic [15:0] CODEC_SHA2_512 = 16'h0013;

  localparam logic [1:0] SHA_TYPE_224 = 2'b00;
  localparam logic [1:0] SHA_TYPE_256 = 2'b01;
  localparam logic [1:0] SHA_TYPE_384 = 2'b10;
  localparam logic [1:0] SHA_TYPE_512 = 2'b11;

  localparam int BS_SMALL  = 64;
  localparam int BS_LARGE  = 128;
  localparam int LF_SMALL  = 8;
  localparam int LF_LARGE  = 16;
  localparam int IN_BYTES  = 8;
  localparam int OUT_BYTES = 64;

`ifdef SHA_PADDER_1024_EN
  localparam int BS_MAX = BS_LARGE;
`else
  localparam int BS_MAX = BS_SMALL;
`endif
  localparam int IDX_W = $clog2(BS_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_PAD,
    S_LENBLK,
    S_EMIT
  } state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sha_codec_decode.sv
// Maps the multicodec identifier carried in TUSER to a 2-bit SHA variant.
// Also used by the message schedule (W(t)) unit.
module sha_codec_decode
  import sha_pkg::*;
#(
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic [C_AXIS_TUSER_WIDTH-1:0] tuser,
  output logic [1:0]                    sha_type
);

  logic [15:0] raw;
  logic [15:0] code;

  assign raw = tuser[CODEC_POS +: 16];
  // A continuation bit in the low byte marks a two-byte varint.
  assign code = raw[7] ? {raw[7:0], raw[15:8]} : raw;

  always_comb begin
    sha_type = SHA_TYPE_224;
    case (code)
      CODEC_SHA2_224: sha_type = SHA_TYPE_224;
      CODEC_SHA2_256: sha_type = SHA_TYPE_256;
      CODEC_SHA2_384: sha_type = SHA_TYPE_384;
      CODEC_SHA2_512: sha_type = SHA_TYPE_512;
      default:        sha_type = SHA_TYPE_224;
    endcase
  end

  logic unused_tuser;
  assign unused_tuser = ^tuser;

endmodule

// File: rtl/sha_padder.sv
// SHA message padder: packs 64-bit message beats into 512/1024-bit padded blocks.
// Define SHA_PADDER_1024_EN to give SHA-384/512 their 128-byte blocks.
module sha_padder
  import sha_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 512,
  parameter int C_AXIS_TUSER_WIDTH  = 128
) (
  input  logic                             axis_aclk,
  input  logic                             axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast
);

  state_t state_reg, state_next;

  logic [7:0]                    blk_reg [BS_MAX];
  logic [7:0]                    ptr_reg;
  logic [60:0]                   cnt_reg;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_reg;
  logic                          big_reg;
  logic                          pad_pending_reg;
  logic                          len_pending_reg;
  logic                          final_reg;
  logic                          beat_reg;

  logic [1:0]  sha_type;
  logic        big_sel;
  logic [7:0]  keep_eff;
  logic [7:0]  ptr_sum;
  logic [63:0] len64;
  logic        last_beat;
  logic        len_fits;
  int          bs_int;
  int          lf_int;

  sha_codec_decode #(
    .C_AXIS_TUSER_WIDTH(C_AXIS_TUSER_WIDTH)
  ) u_codec (
    .tuser    (s_axis_tuser),
    .sha_type (sha_type)
  );

`ifdef SHA_PADDER_1024_EN
  assign big_sel = sha_type[1];
`else
  assign big_sel = 1'b0;
`endif

  logic unused_sha;
  assign unused_sha = ^sha_type;

  assign bs_int    = big_reg ? BS_LARGE : BS_SMALL;
  assign lf_int    = big_reg ? LF_LARGE : LF_SMALL;
  // Only the final beat may be partial; earlier beats are always full.
  assign keep_eff  = s_axis_tlast ? s_axis_tkeep : 8'hFF;
  assign ptr_sum   = ptr_reg + 8'(popcount8(keep_eff));
  assign len64     = {cnt_reg, 3'b000};
  assign last_beat = (beat_reg == big_reg);
  assign len_fits  = (int'(ptr_reg) + 1) <= (bs_int - lf_int);

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (s_axis_tvalid) state_next = S_ACCUM;
      end
      S_ACCUM: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tlast) begin
            state_next = (int'(ptr_sum) < bs_int) ? S_PAD : S_EMIT;
          end else if (int'(ptr_sum) == bs_int) begin
            state_next = S_EMIT;
          end
        end
      end
      S_PAD:    state_next = S_EMIT;
      S_LENBLK: state_next = S_EMIT;
      S_EMIT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = final_reg && last_beat;
        if (m_axis_tready && last_beat) begin
          if (pad_pending_reg)      state_next = S_PAD;
          else if (len_pending_reg) state_next = S_LENBLK;
          else if (final_reg)       state_next = S_IDLE;
          else                      state_next = S_ACCUM;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      for (int i = 0; i < BS_MAX; i++) blk_reg[i] <= '0;
      ptr_reg         <= '0;
      cnt_reg         <= '0;
      tuser_reg       <= '0;
      big_reg         <= 1'b0;
      pad_pending_reg <= 1'b0;
      len_pending_reg <= 1'b0;
      final_reg       <= 1'b0;
      beat_reg        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (s_axis_tvalid) begin
            tuser_reg       <= s_axis_tuser;
            big_reg         <= big_sel;
            ptr_reg         <= '0;
            cnt_reg         <= '0;
            pad_pending_reg <= 1'b0;
            len_pending_reg <= 1'b0;
            final_reg       <= 1'b0;
            beat_reg        <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (s_axis_tvalid) begin
            for (int k = 0; k < IN_BYTES; k++) begin
              if (keep_eff[k]) blk_reg[IDX_W'(ptr_reg + 8'(k))] <= s_axis_tdata[8*k +: 8];
            end
            ptr_reg <= ptr_sum;
            cnt_reg <= cnt_reg + 61'(popcount8(keep_eff));
            if (s_axis_tlast && int'(ptr_sum) == bs_int) pad_pending_reg <= 1'b1;
          end
        end
        S_PAD: begin
          // Length goes in the last 8 bytes; for 16-byte fields the upper half stays zero.
          for (int i = 0; i < BS_MAX; i++) begin
            if (i == int'(ptr_reg)) begin
              blk_reg[i] <= 8'h80;
            end else if (i > int'(ptr_reg)) begin
              if (len_fits && i >= bs_int - 8 && i < bs_int) begin
                blk_reg[i] <= 8'(len64 >> (8 * (bs_int - 1 - i)));
              end else begin
                blk_reg[i] <= 8'h00;
              end
            end
          end
          if (len_fits) final_reg <= 1'b1;
          else          len_pending_reg <= 1'b1;
        end
        S_LENBLK: begin
          for (int i = 0; i < BS_MAX; i++) begin
            if (i >= bs_int - 8 && i < bs_int) blk_reg[i] <= 8'(len64 >> (8 * (bs_int - 1 - i)));
            else                               blk_reg[i] <= 8'h00;
          end
          final_reg       <= 1'b1;
          len_pending_reg <= 1'b0;
        end
        S_EMIT: begin
          if (m_axis_tready) begin
            if (!last_beat) begin
              beat_reg <= 1'b1;
            end else begin
              beat_reg <= 1'b0;
              if (pad_pending_reg) begin
                pad_pending_reg <= 1'b0;
                ptr_reg         <= '0;
              end else if (len_pending_reg) begin
                len_pending_reg <= 1'b0;
              end else if (final_reg) begin
                final_reg <= 1'b0;
              end else begin
                ptr_reg <= '0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_out
    assign m_axis_tdata[8*gi +: 8] = blk_reg[IDX_W'({beat_reg, 6'(gi)})];
  end

  assign m_axis_tuser = tuser_reg;

endmodule

// File: tb/tb_sha_padder.sv
// Randomised self-checking bench for sha_padder against a plain SHA padding model.
module tb_sha_padder;

  logic         axis_aclk = 1'b0;
  logic         axis_reset = 1'b1;
  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tkeep = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [511:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;

  sha_padder dut (
    .axis_aclk     (axis_aclk),
    .axis_reset    (axis_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 axis_aclk = ~axis_aclk;

  int n_checks = 0;
  int n_fail = 0;

  byte unsigned msg_q[$];
  byte unsigned exp_q[$];
  logic [511:0] cap_data[$];
  logic         cap_last[$];
  logic [127:0] cap_user[$];
  logic [127:0] cur_tuser;
  bit           overlap_seen;
  logic [15:0]  codes[5];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 1024-bit blocks only for raw-encoded sha2-384 (0x20) and sha2-512 (0x13).
  function automatic bit is_big(input logic [127:0] u);
`ifdef SHA_PADDER_1024_EN
    return (u[15:0] == 16'h0020) || (u[15:0] == 16'h0013);
`else
    return (u[15:0] == 16'hFFFF) && 1'b0;
`endif
  endfunction

  // Standard SHA padding: message, 0x80, zeros, big-endian bit length in LF bytes.
  task automatic build_expected();
    int bs;
    int lf;
    logic [127:0] len;
    bs = is_big(cur_tuser) ? 128 : 64;
    lf = is_big(cur_tuser) ? 16 : 8;
    exp_q = msg_q;
    exp_q.push_back(8'h80);
    while ((exp_q.size() % bs) != bs - lf) exp_q.push_back(8'h00);
    len = 128'(msg_q.size()) * 128'd8;
    for (int i = lf - 1; i >= 0; i--) exp_q.push_back(8'(len >> (8 * i)));
  endtask

  task automatic drive_msg(input int gap_pct);
    int n;
    int nb;
    int b;
    int guard;
    logic [63:0] d;
    logic [8:0]  m;
    n = msg_q.size();
    nb = (n == 0) ? 1 : (n + 7) / 8;
    b = 0;
    guard = 0;
    while (b < nb && guard < 3000) begin
      @(negedge axis_aclk);
      guard++;
      if ($urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
      end else begin
        d = {$urandom, $urandom};
        for (int j = 0; j < 8; j++) begin
          if (8 * b + j < n) d[8*j +: 8] = msg_q[8*b + j];
        end
        s_axis_tdata = d;
        s_axis_tlast = (b == nb - 1);
        if (b == nb - 1) begin
          m = (9'h1 << (n - 8 * b)) - 9'h1;
          s_axis_tkeep = m[7:0];
        end else begin
          s_axis_tkeep = 8'($urandom);
        end
        s_axis_tuser = (b == 0) ? cur_tuser : {$urandom, $urandom, $urandom, $urandom};
        s_axis_tvalid = 1'b1;
        if (s_axis_tready) b++;
      end
    end
    @(negedge axis_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    check("beats_accepted", 512'(b), 512'(nb));
  endtask

  task automatic collect(input int nb_exp, input int rdy_pct, input int stall_n);
    int got;
    int cyc;
    int stalled;
    bit have_held;
    logic [511:0] held;
    got = 0;
    cyc = 0;
    stalled = 0;
    have_held = 0;
    held = '0;
    cap_data.delete();
    cap_last.delete();
    cap_user.delete();
    while (got < nb_exp && cyc < 4000) begin
      @(negedge axis_aclk);
      cyc++;
      if (s_axis_tready && m_axis_tvalid) overlap_seen = 1;
      if (stalled < stall_n) begin
        m_axis_tready = 1'b0;
        if (m_axis_tvalid) begin
          if (have_held) check("stall_stable", m_axis_tdata, held);
          held = m_axis_tdata;
          have_held = 1;
          stalled++;
        end
      end else begin
        m_axis_tready = ($urandom_range(99) < rdy_pct);
        if (m_axis_tvalid && m_axis_tready) begin
          cap_data.push_back(m_axis_tdata);
          cap_last.push_back(m_axis_tlast);
          cap_user.push_back(m_axis_tuser);
          got++;
        end
      end
    end
    @(negedge axis_aclk);
    m_axis_tready = 1'b0;
    check("beat_count", 512'(got), 512'(nb_exp));
  endtask

  task automatic run_msg(input string name, input int gap_pct, input int rdy_pct, input int stall_n);
    int nb;
    logic [511:0] e;
    build_expected();
    nb = exp_q.size() / 64;
    overlap_seen = 0;
    fork
      drive_msg(gap_pct);
      collect(nb, rdy_pct, stall_n);
    join
    for (int k = 0; k < cap_data.size(); k++) begin
      for (int j = 0; j < 64; j++) e[8*j +: 8] = exp_q[64*k + j];
      check($sformatf("%s_data%0d", name, k), cap_data[k], e);
      check($sformatf("%s_last%0d", name, k), 512'(cap_last[k]), 512'(k == nb - 1));
      check($sformatf("%s_user%0d", name, k), 512'(cap_user[k]), 512'(cur_tuser));
    end
    check({name, "_overlap"}, 512'(overlap_seen), 512'(0));
    check({name, "_idle"}, 512'(m_axis_tvalid), 512'(0));
    $display("msg %s len=%0d code=%h beats=%0d", name, msg_q.size(), cur_tuser[15:0], cap_data.size());
  endtask

  task automatic set_abc(input logic [15:0] code);
    msg_q = '{8'h61, 8'h62, 8'h63};
    cur_tuser = {$urandom, $urandom, $urandom, 16'($urandom), code};
  endtask

  task automatic set_len(input int n, input logic [15:0] code);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
    cur_tuser = {$urandom, $urandom, $urandom, 16'($urandom), code};
  endtask

  initial begin
    int seen;
    codes = '{16'h2093, 16'h0012, 16'h0020, 16'h0013, 16'h2193};
    repeat (3) @(negedge axis_aclk);
    check("rst_s_tready", 512'(s_axis_tready), 512'(0));
    check("rst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
    check("rst_m_tlast", 512'(m_axis_tlast), 512'(0));
    check("rst_m_tuser", 512'(m_axis_tuser), 512'(0));
    axis_reset = 1'b0;

    set_abc(16'h0012);
    run_msg("abc256", 0, 100, 0);
    if (cap_data.size() > 0) begin
      check("abc256_b3", 512'(cap_data[0][31:0]), 512'(32'h80636261));
      check("abc256_b63", 512'(cap_data[0][511:504]), 512'(8'h18));
      check("abc256_mid", 512'(cap_data[0][503:32]), 512'(0));
    end

    set_len(56, 16'h0012);
    run_msg("len56", 10, 80, 0);
    if (cap_data.size() == 2) begin
      check("len56_b56", 512'(cap_data[0][455:448]), 512'(8'h80));
      check("len56_blk2", 512'(cap_data[1]), {16'hC001, 496'h0});
    end

    set_len(64, 16'h0012);
    run_msg("len64", 0, 100, 0);
    if (cap_data.size() == 2) begin
      check("len64_blk2", 512'(cap_data[1]), {16'h0002, 488'h0, 8'h80});
    end

    msg_q.delete();
    cur_tuser = {$urandom, $urandom, $urandom, 16'($urandom), 16'h0012};
    run_msg("empty", 0, 100, 5);
    if (cap_data.size() > 0) check("empty_blk", cap_data[0], 512'h80);

    set_abc(16'h0013);
    run_msg("abc512", 0, 60, 0);
`ifdef SHA_PADDER_1024_EN
    if (cap_data.size() == 2) begin
      check("abc512_b3", 512'(cap_data[0][31:24]), 512'(8'h80));
      check("abc512_b127", 512'(cap_data[1][511:504]), 512'(8'h18));
    end
`else
    if (cap_data.size() == 1) check("abc512_b63", 512'(cap_data[0][511:504]), 512'(8'h18));
`endif

    set_abc(16'h2093);
    run_msg("abc224", 0, 100, 0);

    for (int t = 0; t < 40; t++) begin
      set_len($urandom_range(0, 200), codes[$urandom_range(0, 4)]);
      run_msg($sformatf("rnd%0d", t), 25, 70, 0);
    end

    // Abort a message while its block is being offered.
    set_len(56, 16'h0012);
    m_axis_tready = 1'b0;
    drive_msg(0);
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge axis_aclk);
      if (m_axis_tvalid) seen = 1;
    end
    check("emit_reached", 512'(seen), 512'(1));
    axis_reset = 1'b1;
    @(negedge axis_aclk);
    check("rst_emit_tvalid", 512'(m_axis_tvalid), 512'(0));
    check("rst_emit_tready", 512'(s_axis_tready), 512'(0));
    check("rst_emit_tuser", 512'(m_axis_tuser), 512'(0));
    axis_reset = 1'b0;
    m_axis_tready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge axis_aclk);
      if (m_axis_tvalid) seen = 1;
    end
    m_axis_tready = 1'b0;
    check("rst_no_beats", 512'(seen), 512'(0));
    $display("msg reset_abort len=56");

    set_abc(16'h0012);
    run_msg("recover", 0, 100, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
